mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds to the pipeline's data-memory store/load interface in the MEM stage. The core acts as initiator, driving a word address, store data and a write strobe. This block decodes its own address window, queues bytes in a small FIFO and serialises them on a single TX line as 8N1 frames. Status and divisor registers are read back combinationally in the same cycle, alongside the data-memory read mux.

---
 rtl/mmio_uart_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MEM-stage mapped 8N1 UART transmitter with a small byte FIFO.
// Ports: clk/reset(async, low), AddrM/WriteDataM/MemWriteM in, ReadDataM/SelM/tx/irq out.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  output logic [31:0] ReadDataM,
  output logic        SelM,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_e;

  // address decode
  logic       hit;
  logic [1:0] regSel;
  logic       rdStatus;
  logic       rdDiv;
  logic       wrTx;
  logic       wrStatus;
  logic       wrDiv;

  assign hit      = AddrM[31:4] == BASE_ADDR[31:4];
  assign regSel   = AddrM[3:2];
  assign SelM     = hit;
  assign rdStatus = hit && (regSel == 2'd1);
  assign rdDiv    = hit && (regSel == 2'd2);
  assign wrTx     = hit && MemWriteM && (regSel == 2'd0);
  assign wrStatus = hit && MemWriteM && (regSel == 2'd1);
  assign wrDiv    = hit && MemWriteM && (regSel == 2'd2);

  logic unusedBits;
  assign unusedBits = ^{AddrM[1:0], WriteDataM[31:16]};

  // FIFO
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          empty;
  logic          full;
  logic          push;
  logic          drop;
  logic          pop;

  // extra pointer bit distinguishes full from empty when indices match
  assign empty = wrPtr == rdPtr;
  assign full  = (wrPtr[PW-1] != rdPtr[PW-1]) &&
                 (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  // full is sampled before any same-cycle pop, so a push into a
  // full FIFO is dropped even while the head is leaving
  assign push = wrTx && !full;
  assign drop = wrTx && full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr[AW-1:0]] <= WriteDataM[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
    end
  end

  // control registers
  logic        ovf;
  logic [15:0] div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      div <= DIV_RST;
    end else begin
      // a dropped push wins over a clear in the same cycle
      if (drop) begin
        ovf <= 1'b1;
      end else if (wrStatus && WriteDataM[3]) begin
        ovf <= 1'b0;
      end
      if (wrDiv) begin
        div <= (WriteDataM[15:0] == 16'd0) ? 16'd1 : WriteDataM[15:0];
      end
    end
  end

  // serialiser
  txState_e    state;
  txState_e    stateNext;
  logic [7:0]  shift;
  logic [7:0]  shiftNext;
  logic [15:0] bitDiv;
  logic [15:0] bitDivNext;
  logic [15:0] cycCnt;
  logic [15:0] cycNext;
  logic [2:0]  bitCnt;
  logic [2:0]  bitNext;
  logic        txNext;
  logic        bitDone;
  logic        busy;

  assign busy    = state != IDLE;
  assign pop     = (state == IDLE) && !empty;
  assign bitDone = cycCnt == (bitDiv - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shift  <= 8'd0;
      bitDiv <= DIV_RST;
      cycCnt <= 16'd0;
      bitCnt <= 3'd0;
      tx     <= 1'b1;
      irq    <= 1'b1;
    end else begin
      state  <= stateNext;
      shift  <= shiftNext;
      bitDiv <= bitDivNext;
      cycCnt <= cycNext;
      bitCnt <= bitNext;
      tx     <= txNext;
      irq    <= (state == IDLE) && empty;
    end
  end

  always_comb begin
    stateNext  = state;
    shiftNext  = shift;
    bitDivNext = bitDiv;
    cycNext    = cycCnt;
    bitNext    = bitCnt;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          stateNext  = START;
          shiftNext  = fifoMem[rdPtr[AW-1:0]];
          // divisor is frozen for the whole frame
          bitDivNext = div;
          cycNext    = 16'd0;
          bitNext    = 3'd0;
        end
      end
      START: begin
        if (bitDone) begin
          stateNext = DATA;
          cycNext   = 16'd0;
        end else begin
          cycNext = cycCnt + 16'd1;
        end
      end
      DATA: begin
        if (bitDone) begin
          cycNext   = 16'd0;
          shiftNext = shift >> 1;
          if (bitCnt == 3'd7) begin
            stateNext = STOP;
          end else begin
            bitNext = bitCnt + 3'd1;
          end
        end else begin
          cycNext = cycCnt + 16'd1;
        end
      end
      STOP: begin
        if (bitDone) begin
          stateNext = IDLE;
          cycNext   = 16'd0;
        end else begin
          cycNext = cycCnt + 16'd1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // line level is registered from the next state so tx is glitch-free
  always_comb begin
    txNext = 1'b1;
    unique case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
      default: txNext = 1'b1;
    endcase
  end

  // read mux
  always_comb begin
    ReadDataM = 32'd0;
    unique case (1'b1)
      rdStatus: ReadDataM = {27'd0, irq, ovf, busy, empty, full};
      rdDiv:    ReadDataM = {16'd0, div};
      default:  ReadDataM = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and random stores/loads against a frame-level model.
// Drives the MEM-stage bus, checks tx/irq/read data every cycle.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] AddrM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ReadDataM;
  logic        SelM;
  logic        tx;
  logic        irq;

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .AddrM(AddrM),
    .WriteDataM(WriteDataM),
    .MemWriteM(MemWriteM),
    .ReadDataM(ReadDataM),
    .SelM(SelM),
    .tx(tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: a frame is (start edge, divisor, byte); line level is
  // derived arithmetically from the distance to the start edge
  logic [7:0]  q[$];
  int          n;
  bit          haveF;
  int          fs;
  int          fd;
  logic [7:0]  fb;
  logic        mOvf;
  logic        mIrq;
  logic [15:0] mDiv;

  task automatic mReset();
    q.delete();
    n     = 0;
    haveF = 0;
    fs    = 0;
    fd    = 1;
    fb    = 8'd0;
    mOvf  = 1'b0;
    mIrq  = 1'b1;
    mDiv  = 16'(CPB);
  endtask

  function automatic bit mBusy();
    return haveF && (n >= fs) && (n < fs + 10 * fd);
  endfunction

  function automatic logic mTx();
    int p;
    if (!mBusy()) return 1'b1;
    p = (n - fs) / fd;
    if (p == 0) return 1'b0;
    if (p <= 8) return fb[p-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] mStatus();
    logic [31:0] s;
    s = 32'd0;
    s[4] = mIrq;
    s[3] = mOvf;
    s[2] = mBusy();
    s[1] = (q.size() == 0);
    s[0] = (q.size() == DEPTH);
    return s;
  endfunction

  function automatic bit inWin(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a);
    if (!inWin(a)) return 32'd0;
    case (a[3:2])
      2'd1:    return mStatus();
      2'd2:    return {16'd0, mDiv};
      default: return 32'd0;
    endcase
  endfunction

  task automatic mStep();
    bit bPrev;
    bit ePrev;
    bit fPrev;
    bPrev = mBusy();
    ePrev = (q.size() == 0);
    fPrev = (q.size() == DEPTH);
    n++;
    mIrq = !bPrev && ePrev;
    if (!bPrev && !ePrev) begin
      haveF = 1;
      fs    = n;
      fd    = int'(mDiv);
      fb    = q.pop_front();
    end
    if (MemWriteM && inWin(AddrM)) begin
      case (AddrM[3:2])
        2'd0: begin
          if (fPrev) mOvf = 1'b1;
          else q.push_back(WriteDataM[7:0]);
        end
        2'd1: if (WriteDataM[3]) mOvf = 1'b0;
        2'd2: mDiv = (WriteDataM[15:0] == 16'd0) ? 16'd1
                                                  : WriteDataM[15:0];
        default: ;
      endcase
    end
  endtask

  // apply inputs, check pre-edge state, consume one edge
  task automatic cycle(input logic [31:0] a, input logic we,
                       input logic [31:0] wd);
    AddrM      = a;
    MemWriteM  = we;
    WriteDataM = wd;
    @(negedge clk);
    chk("tx", {31'd0, tx}, {31'd0, mTx()});
    chk("irq", {31'd0, irq}, {31'd0, mIrq});
    chk("sel", {31'd0, SelM}, {31'd0, inWin(a)});
    chk("rd", ReadDataM, mRead(a));
    @(posedge clk);
    mStep();
    #1;
  endtask

  task automatic idle(input int cnt, input logic [31:0] a);
    for (int i = 0; i < cnt; i++) cycle(a, 1'b0, 32'd0);
  endtask

  function automatic logic expTx55(input int j);
    logic [7:0] v;
    v = 8'h55;
    if (j >= 1 && j <= 4) return 1'b0;
    if (j >= 5 && j <= 36) return v[(j-5)/4];
    return 1'b1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int busyCnt;
    int r;
    int k;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;

    mReset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd1);
    AddrM = BASE + 32'h4;
    #1;
    chk("rst_stat", ReadDataM, 32'h12);
    AddrM = BASE + 32'h8;
    #1;
    chk("rst_div", ReadDataM, 32'd4);
    reset = 1'b1;
    idle(3, BASE + 32'h4);

    // single 0x55 frame
    cycle(BASE, 1'b1, 32'h55);
    busyCnt = 0;
    for (int j = 1; j <= 50; j++) begin
      cycle(BASE + 32'h4, 1'b0, 32'd0);
      chk("f55_tx", {31'd0, tx}, {31'd0, expTx55(j)});
      if (ReadDataM[2]) busyCnt++;
    end
    chk("f55_busy", busyCnt, 32'd40);
    chk("f55_irq", {31'd0, irq}, 32'd1);

    // six stores into a depth-4 FIFO
    for (int i = 1; i <= 6; i++) cycle(BASE, 1'b1, i);
    cycle(BASE + 32'h4, 1'b0, 32'd0);
    chk("six_full", {31'd0, ReadDataM[0]}, 32'd1);
    chk("six_ovf", {31'd0, ReadDataM[3]}, 32'd1);
    cycle(BASE + 32'h4, 1'b1, 32'h8);
    chk("ovf_clr", {31'd0, ReadDataM[3]}, 32'd0);
    idle(230, BASE + 32'h4);
    chk("six_idle", ReadDataM, 32'h12);

    // divisor change mid-frame
    cycle(BASE, 1'b1, 32'h41);
    idle(10, BASE);
    cycle(BASE + 32'h8, 1'b1, 32'd8);
    cycle(BASE + 32'h8, 1'b0, 32'd0);
    chk("div8", ReadDataM, 32'd8);
    cycle(BASE, 1'b1, 32'h9C);
    idle(150, BASE + 32'h4);
    cycle(BASE + 32'h8, 1'b1, 32'd0);
    cycle(BASE + 32'h8, 1'b0, 32'd0);
    chk("div0", ReadDataM, 32'd1);
    cycle(BASE + 32'h8, 1'b1, 32'd4);
    idle(2, BASE);

    // reset mid-DATA with two bytes queued
    cycle(BASE, 1'b1, 32'hA5);
    cycle(BASE, 1'b1, 32'h3C);
    cycle(BASE, 1'b1, 32'h0F);
    idle(8, BASE);
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    MemWriteM = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_tx", {31'd0, tx}, 32'd1);
    chk("arst_irq", {31'd0, irq}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    mReset();
    cycle(BASE + 32'h4, 1'b0, 32'd0);
    chk("arst_stat", ReadDataM, 32'h12);
    idle(60, BASE + 32'h4);

    // outside the window
    cycle(BASE + 32'h10, 1'b0, 32'd0);
    chk("oow_sel_hi", {31'd0, SelM}, 32'd0);
    chk("oow_rd_hi", ReadDataM, 32'd0);
    cycle(BASE - 32'h4, 1'b0, 32'd0);
    chk("oow_sel_lo", {31'd0, SelM}, 32'd0);
    chk("oow_rd_lo", ReadDataM, 32'd0);
    cycle(BASE + 32'h10, 1'b1, 32'h77);
    cycle(BASE - 32'h4, 1'b1, 32'h77);
    cycle(BASE + 32'hC, 1'b1, 32'h33);
    chk("rsv_sel", {31'd0, SelM}, 32'd1);
    chk("rsv_rd", ReadDataM, 32'd0);
    idle(20, BASE + 32'h4);
    chk("oow_stat", ReadDataM, 32'h12);
    chk("oow_tx", {31'd0, tx}, 32'd1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      r  = $urandom_range(0, 99);
      wd = $urandom;
      we = 1'b0;
      if (r < 5) begin
        we = 1'b1;
        a  = BASE + 32'($urandom_range(0, 3));
      end else if (r < 7) begin
        we = 1'b1;
        a  = BASE + 32'h4 + 32'($urandom_range(0, 3));
      end else if (r < 8) begin
        we = 1'b1;
        a  = BASE + 32'h8;
        wd = {wd[31:16], 16'($urandom_range(0, 5))};
      end else if (r < 10) begin
        we = 1'b1;
        k  = $urandom_range(0, 2);
        a  = (k == 0) ? BASE + 32'hC :
             (k == 1) ? BASE + 32'h10 : BASE - 32'h4;
      end else begin
        k = $urandom_range(0, 5);
        if (k < 4) a = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
        else if (k == 4) a = BASE + 32'h10 + 32'($urandom_range(0, 15));
        else a = $urandom;
      end
      cycle(a, we, wd);
    end
    idle(100, BASE + 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
